// File: rtl/screen_flow_controller.sv
// Game-flow sequencer: tracks phase, lives and per-frame pause timers, and
// selects the composed screen that goes to the VGA output.
//
// state | meaning
// ------+-----------------------------------------------
// START | title screen, waiting for keyStart
// PLAY  | active play, physics running
// LOST  | ball-lost pause, main screen flashes
// OVER  | game-over screen held for OVER_FRAMES frames
module screen_flow_controller #(
    parameter int LIVES_INIT   = 3,
    parameter int LOST_FRAMES  = 60,
    parameter int OVER_FRAMES  = 180,
    parameter int FLASH_PERIOD = 8
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       startOfFrame,
    input  logic       keyStart,
    input  logic       ballLost,
    input  logic [7:0] RGB_screen_start,
    input  logic [7:0] RGB_screen_main,
    input  logic [7:0] RGB_screen_over,
    output logic [7:0] RGB_out,
    output logic       freeze,
    output logic       gameActive,
    output logic [1:0] lives,
    output logic [1:0] state
);

    localparam int FLASH_BIT = $clog2(FLASH_PERIOD);

    typedef enum logic [1:0] {
        ST_START = 2'd0,
        ST_PLAY  = 2'd1,
        ST_LOST  = 2'd2,
        ST_OVER  = 2'd3
    } phase_t;

    phase_t     cur;
    phase_t     nxt;
    logic [1:0] lives_nxt;
    logic [7:0] cnt;
    logic [7:0] cnt_nxt;
    logic [7:0] pix_sel;

    assign state = cur;

    always_comb begin
        nxt       = cur;
        lives_nxt = lives;
        cnt_nxt   = cnt;
        case (cur)
            ST_START: begin
                if (keyStart) begin
                    nxt       = ST_PLAY;
                    lives_nxt = 2'(LIVES_INIT);
                end
            end
            ST_PLAY: begin
                if (ballLost) begin
                    if (lives > 2'd1) begin
                        nxt       = ST_LOST;
                        lives_nxt = lives - 2'd1;
                    end else begin
                        nxt       = ST_OVER;
                        lives_nxt = 2'd0;
                    end
                end
            end
            ST_LOST: begin
                if (startOfFrame) begin
                    if (cnt == 8'(LOST_FRAMES - 1)) nxt = ST_PLAY;
                    else                            cnt_nxt = cnt + 8'd1;
                end
            end
            ST_OVER: begin
                lives_nxt = 2'd0;
                if (startOfFrame) begin
                    if (cnt == 8'(OVER_FRAMES - 1)) nxt = ST_START;
                    else                            cnt_nxt = cnt + 8'd1;
                end
            end
            default: nxt = ST_START;
        endcase
        // a frame pulse coinciding with a transition is not counted in the new phase
        if (nxt != cur) cnt_nxt = 8'd0;
    end

    always_comb begin
        pix_sel = RGB_screen_start;
        case (cur)
            ST_START: pix_sel = RGB_screen_start;
            ST_PLAY:  pix_sel = RGB_screen_main;
            ST_LOST:  pix_sel = cnt[FLASH_BIT] ? ~RGB_screen_main : RGB_screen_main;
            ST_OVER:  pix_sel = RGB_screen_over;
            default:  pix_sel = RGB_screen_start;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            cur        <= ST_START;
            lives      <= 2'd0;
            cnt        <= 8'd0;
            RGB_out    <= 8'h00;
            freeze     <= 1'b1;
            gameActive <= 1'b0;
        end else begin
            cur        <= nxt;
            lives      <= lives_nxt;
            cnt        <= cnt_nxt;
            RGB_out    <= pix_sel;
            gameActive <= (nxt == ST_PLAY);
            freeze     <= (nxt != ST_PLAY);
        end
    end

endmodule
